// File: rtl/fpu_pkg.sv
// Shared FP32 types and constants for the add issue/retire stage.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic bypass;
  } add_flags_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [7:0]  FP32_EXP_MIN = 8'h00;

  // Signed infinity of the requested polarity.
  function automatic fp32_t fp32_inf(input logic sign);
    fp32_t r;
    r.sign = sign;
    r.exp  = FP32_EXP_MAX;
    r.mant = 23'h00_0000;
    return r;
  endfunction

  // Signed zero of the requested polarity.
  function automatic fp32_t fp32_zero(input logic sign);
    fp32_t r;
    r.sign = sign;
    r.exp  = FP32_EXP_MIN;
    r.mant = 23'h00_0000;
    return r;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Classifies one FP32 operand and flushes denormals to a signed zero.
module fp32_classify
  import fpu_pkg::*;
(
  input  fp32_t op,
  output fp32_t flushed,
  output logic  is_zero,
  output logic  is_inf,
  output logic  is_nan,
  output logic  is_snan
);

  logic exp_min_s;
  logic exp_max_s;
  logic mant_zero_s;

  // Decode exponent/mantissa extremes and derive the operand class.
  always_comb begin
    exp_min_s   = (op.exp == FP32_EXP_MIN);
    exp_max_s   = (op.exp == FP32_EXP_MAX);
    mant_zero_s = (op.mant == 23'h00_0000);
    flushed     = op;
    if (exp_min_s && !mant_zero_s) begin
      flushed = fp32_zero(op.sign);
    end else begin
      flushed = op;
    end
    // Denormals count as zero once flushed.
    is_zero = exp_min_s;
    is_inf  = exp_max_s && mant_zero_s;
    is_nan  = exp_max_s && !mant_zero_s;
    is_snan = exp_max_s && !mant_zero_s && !op.mant[22];
  end

endmodule

// File: rtl/fp32_add_issue.sv
// Issue/retire stage around a combinational FP32 adder: operand FIFO,
// special-case resolution and a valid/ready output register.
module fp32_add_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  input  logic             add_overflow,
  input  logic             add_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // FIFO storage and pointers
  logic [31:0]      mem_a_q   [DEPTH];
  logic [31:0]      mem_a_d   [DEPTH];
  logic [31:0]      mem_b_q   [DEPTH];
  logic [31:0]      mem_b_d   [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  add_flags_t       out_flags_q, out_flags_d;

  // Handshake and resolution nets
  logic       full_s;
  logic       push_s;
  logic       issue_s;
  fp32_t      a_raw_s, b_raw_s;
  fp32_t      a_f_s, b_f_s;
  logic       a_zero_s, a_inf_s, a_nan_s, a_snan_s;
  logic       b_zero_s, b_inf_s, b_nan_s, b_snan_s;
  fp32_t      res_value_s;
  add_flags_t res_flags_s;

  assign full_s   = (count_q == CNT_FULL);
  assign in_ready = nRST && !full_s;
  assign push_s   = in_valid && in_ready;
  assign issue_s  = (count_q != {CNT_W{1'b0}}) && (!out_valid_q || out_ready);

  assign add_a   = mem_a_q[rd_ptr_q];
  assign add_b   = mem_b_q[rd_ptr_q];
  assign a_raw_s = fp32_t'(add_a);
  assign b_raw_s = fp32_t'(add_b);

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;

  fp32_classify u_class_a (
    .op      (a_raw_s),
    .flushed (a_f_s),
    .is_zero (a_zero_s),
    .is_inf  (a_inf_s),
    .is_nan  (a_nan_s),
    .is_snan (a_snan_s)
  );

  fp32_classify u_class_b (
    .op      (b_raw_s),
    .flushed (b_f_s),
    .is_zero (b_zero_s),
    .is_inf  (b_inf_s),
    .is_nan  (b_nan_s),
    .is_snan (b_snan_s)
  );

  // Resolve IEEE special cases ahead of the adder result, highest priority first.
  always_comb begin
    res_value_s = fp32_t'(add_result);
    res_flags_s = '0;
    if (a_nan_s || b_nan_s) begin
      res_value_s        = fp32_t'(FP32_QNAN);
      res_flags_s.nv     = a_snan_s || b_snan_s;
      res_flags_s.bypass = 1'b1;
    end else if (a_inf_s && b_inf_s && (a_f_s.sign != b_f_s.sign)) begin
      res_value_s        = fp32_t'(FP32_QNAN);
      res_flags_s.nv     = 1'b1;
      res_flags_s.bypass = 1'b1;
    end else if (a_inf_s) begin
      res_value_s        = a_f_s;
      res_flags_s.bypass = 1'b1;
    end else if (b_inf_s) begin
      res_value_s        = b_f_s;
      res_flags_s.bypass = 1'b1;
    end else if (a_zero_s && b_zero_s) begin
      res_value_s        = fp32_zero(a_f_s.sign && b_f_s.sign);
      res_flags_s.bypass = 1'b1;
    end else if (a_zero_s) begin
      res_value_s        = b_f_s;
      res_flags_s.bypass = 1'b1;
    end else if (b_zero_s) begin
      res_value_s        = a_f_s;
      res_flags_s.bypass = 1'b1;
    end else if ((a_f_s.sign != b_f_s.sign) &&
                 (a_f_s.exp == b_f_s.exp) && (a_f_s.mant == b_f_s.mant)) begin
      // Exact cancellation always yields +0 in round-to-nearest.
      res_value_s        = fp32_zero(1'b0);
      res_flags_s.bypass = 1'b1;
    end else if (add_overflow) begin
      res_value_s    = fp32_inf(add_result[31]);
      res_flags_s.of = 1'b1;
    end else if (add_underflow) begin
      res_value_s    = fp32_zero(add_result[31]);
      res_flags_s.uf = 1'b1;
    end else begin
      res_value_s = fp32_t'(add_result);
      res_flags_s = '0;
    end
  end

  // Next-state for FIFO push/pop, occupancy and the output register.
  always_comb begin
    mem_a_d      = mem_a_q;
    mem_b_d      = mem_b_q;
    mem_tag_d    = mem_tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_flags_d  = out_flags_q;

    if (push_s) begin
      mem_a_d[wr_ptr_q]   = in_a;
      mem_b_d[wr_ptr_q]   = in_b;
      mem_tag_d[wr_ptr_q] = in_tag;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (issue_s) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      out_valid_d  = 1'b1;
      out_result_d = res_value_s;
      out_tag_d    = mem_tag_q[rd_ptr_q];
      out_flags_d  = res_flags_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case ({push_s, issue_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low reset discarding all requests.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i]   <= 32'h0000_0000;
        mem_b_q[i]   <= 32'h0000_0000;
        mem_tag_q[i] <= {TAG_W{1'b0}};
      end
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= 32'h0000_0000;
      out_tag_q    <= {TAG_W{1'b0}};
      out_flags_q  <= '0;
    end else begin
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mem_tag_q    <= mem_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_flags_q  <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp32_add_issue.sv
// Scoreboard bench for fp32_add_issue with a behavioural adder and resolver model.
module tb_fp32_add_issue;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      add_a, add_b, add_result;
  logic             add_overflow, add_underflow;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [39:0] scoreboard [$];
  logic [39:0] mon_e;
  logic [35:0] mon_r;
  logic [33:0] mon_add;
  int          acc_cyc [16];
  int          ret_cyc [16];

  logic        dir_valid;
  logic [31:0] dir_res;
  logic [3:0]  dir_flags;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  fp32_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_result    (add_result),
    .add_overflow  (add_overflow),
    .add_underflow (add_underflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .out_flags     (out_flags)
  );

  // Stand-in adder: {overflow, underflow, result}. Not real arithmetic, just a
  // deterministic function the resolver model can rely on.
  function automatic logic [33:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ov, un;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
    else r = {((a[30:0] >= b[30:0]) ? a[31] : b[31]), a[30:0] ^ {b[22:0], b[30:23]}};
    ov = (a[30:23] >= 8'hFE) && (b[30:23] >= 8'hFE);
    un = (a[30:23] == 8'h01) && (b[30:23] == 8'h01);
    return {ov, un, r};
  endfunction

  assign {add_overflow, add_underflow, add_result} = adder_model(add_a, add_b);

  // Expected {result, flags{nv,of,uf,bypass}} from the priority rules.
  function automatic logic [35:0] ref_resolve(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] ar, input logic ov,
                                              input logic un);
    logic [31:0] fa, fb;
    logic na, nb, sa, sb, ia, ib, za, zb;
    fa = (a[30:23] == 8'h00) ? {a[31], 31'd0} : a;
    fb = (b[30:23] == 8'h00) ? {b[31], 31'd0} : b;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sa = na && !a[22];
    sb = nb && !b[22];
    ia = (a[30:0] == 31'h7F80_0000);
    ib = (b[30:0] == 31'h7F80_0000);
    za = (fa[30:0] == 31'd0);
    zb = (fb[30:0] == 31'd0);
    if (na || nb)                    return {32'h7FC0_0000, (sa || sb), 3'b001};
    if (ia && ib && (a[31] != b[31])) return {32'h7FC0_0000, 4'b1001};
    if (ia)                          return {a, 4'b0001};
    if (ib)                          return {b, 4'b0001};
    if (za && zb)                    return {(a[31] & b[31]), 31'd0, 4'b0001};
    if (za)                          return {fb, 4'b0001};
    if (zb)                          return {fa, 4'b0001};
    if ((fa[30:0] == fb[30:0]) && (fa[31] != fb[31])) return {32'd0, 4'b0001};
    if (ov)                          return {ar[31], 8'hFF, 23'd0, 4'b0100};
    if (un)                          return {ar[31], 31'd0, 4'b0010};
    return {ar, 4'b0000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = {r[31], 31'd0};
      1: r = {r[31], 8'h00, r[22:1], 1'b1};
      2: r = {r[31], 8'hFF, 23'd0};
      3: r = {r[31], 8'hFF, 1'b1, r[21:0]};
      4: r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      5: r = {r[31], 8'hFE, r[22:0]};
      6: r = {r[31], 8'h01, r[22:0]};
      default: r = r;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // Monitor: record accepted requests and compare every retired result in order.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (in_valid && in_ready) begin
        mon_add = adder_model(in_a, in_b);
        mon_r   = ref_resolve(in_a, in_b, mon_add[31:0], mon_add[33], mon_add[32]);
        if (dir_valid) mon_e = {dir_res, in_tag, dir_flags};
        else           mon_e = {mon_r[35:4], in_tag, mon_r[3:0]};
        scoreboard.push_back(mon_e);
        acc_cyc[in_tag] = cyc;
      end
      if (out_valid && out_ready) begin
        if (scoreboard.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output got=%h expected=none", out_result);
        end else begin
          mon_e = scoreboard.pop_front();
          check("result", out_result, mon_e[39:8]);
          check("tag", {28'd0, out_tag}, {28'd0, mon_e[7:4]});
          check("flags", {28'd0, out_flags}, {28'd0, mon_e[3:0]});
          ret_cyc[out_tag] = cyc;
        end
      end
    end
  end

  task automatic send_dir(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] res, input logic [3:0] flags);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    dir_res = res; dir_flags = flags; dir_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; dir_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic take;
    nRST = 1'b0; in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000;
    in_tag = 4'd0; out_ready = 1'b0; dir_valid = 1'b0; dir_res = 32'd0; dir_flags = 4'd0;
    for (int i = 0; i < 16; i++) begin acc_cyc[i] = 0; ret_cyc[i] = 0; end

    // Reset held two cycles with a request offered
    repeat (2) begin
      @(posedge CLK); #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
    end
    nRST = 1'b1; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Basic add and two-cycle latency
    out_ready = 1'b1;
    in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_tag = 4'd1; in_valid = 1'b1;
    dir_res = 32'h4040_0000; dir_flags = 4'b0000; dir_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; dir_valid = 1'b0;
    check("lat_edge_n", {31'd0, out_valid}, 32'd0);
    @(posedge CLK); #1;
    check("lat_edge_n1", {31'd0, out_valid}, 32'd1);
    repeat (2) @(posedge CLK);
    #1;

    // Special cases with literal expectations
    send_dir(32'h7F80_0000, 32'hFF80_0000, 4'd2, 32'h7FC0_0000, 4'b1001);
    send_dir(32'h7F80_0001, 32'h3F80_0000, 4'd3, 32'h7FC0_0000, 4'b1001);
    send_dir(32'h8000_0000, 32'h8000_0000, 4'd4, 32'h8000_0000, 4'b0001);
    send_dir(32'h3F80_0000, 32'hBF80_0000, 4'd5, 32'h0000_0000, 4'b0001);
    send_dir(32'h0000_0001, 32'h3F80_0000, 4'd6, 32'h3F80_0000, 4'b0001);
    send_dir(32'h7F7F_FFFF, 32'h7F7F_FFFF, 4'd7, 32'h7F80_0000, 4'b0100);
    check("sb_empty_directed", scoreboard.size(), 32'd0);

    // Backpressure: out_ready low, offer tags 0..3
    for (int i = 0; i < 16; i++) begin acc_cyc[i] = -1000; ret_cyc[i] = -1000; end
    out_ready = 1'b0;
    acc = 0; in_tag = 4'd0; in_a = rand_op(); in_b = rand_op(); in_valid = 1'b1;
    repeat (6) begin
      @(negedge CLK); take = in_ready;
      @(posedge CLK); #1;
      if (take) begin acc++; in_tag = 4'(acc); in_a = rand_op(); in_b = rand_op(); end
    end
    check("bp_accepted", acc, 32'd3);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_tag", {28'd0, out_tag}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && acc < 4; k++) begin
      @(negedge CLK); take = in_ready;
      @(posedge CLK); #1;
      if (take) acc++;
    end
    in_valid = 1'b0;
    check("bp_tag3_accepted", acc, 32'd4);
    repeat (6) @(posedge CLK);
    #1;
    check("bp_b2b_01", ret_cyc[1] - ret_cyc[0], 32'd1);
    check("bp_b2b_12", ret_cyc[2] - ret_cyc[1], 32'd1);
    check("bp_tag3_lat", ret_cyc[3] - acc_cyc[3], 32'd2);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = ($urandom_range(0, 7) == 0) ? (in_a ^ 32'h8000_0000) : rand_op();
      in_tag    = 4'($urandom);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && (scoreboard.size() != 0 || out_valid); k++) begin
      @(posedge CLK); #1;
    end
    check("drain_sb", scoreboard.size(), 32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation discards everything in flight
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) begin
      in_a = rand_op(); in_b = rand_op(); in_tag = 4'($urandom);
      @(posedge CLK); #1;
    end
    nRST = 1'b0; in_valid = 1'b0;
    scoreboard.delete();
    repeat (2) @(posedge CLK);
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_tag", {28'd0, out_tag}, 32'd0);
    nRST = 1'b1; out_ready = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("midrst_idle", {31'd0, out_valid}, 32'd0);
    check("final_sb_empty", scoreboard.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_add_issue.md
# fp32_add_issue

Sequential issue/retire stage wrapped around the combinational single-precision adder. It buffers operand pairs in a small FIFO and drives the head entry into the adder. It captures the adder's result into an output register with valid/ready handshake and resolves IEEE special cases (zero, denormal, inf, NaN, exact cancellation, overflow/underflow) that the adder datapath does not handle.

## Interface
- DEPTH, 2, operand FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque request tag carried to the output
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  synchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept; equals !full, forced 0 while nRST=0
- in_a, in_b  in  32  FP32 operands
- in_tag  in  TAG_W  request tag
- add_a, add_b  out  32  operands to adder, driven from FIFO head storage (flops only)
- add_result  in  32  adder result
- add_overflow, add_underflow  in  1  adder exponent flags
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts
- out_result  out  32  FP32 result
- out_tag  out  TAG_W  tag of the retired request
- out_flags  out  4  {nv, of, uf, bypass}

## Operation
- Push: in_valid && in_ready writes {a, b, tag} at wr_ptr. Pointers are log2(DEPTH) bits and wrap naturally. count ranges 0..DEPTH.
- Issue: fires when count>0 && (!out_valid || out_ready). It pops the head and loads the output register with the resolved result and tag. out_valid is set.
- Retire: out_valid && out_ready && no issue → out_valid cleared. Retire and issue in the same cycle → register reloaded and out_valid stays 1.
- Classification of each operand is performed by fp32_classify:
  - Denormal (exp=0, mant≠0) is flushed to ±0, with its sign kept.
  - Each operand is tagged zero, inf, NaN or sNaN (NaN with mant[22]=0).
- Resolution priority:
  1. Either NaN → 0x7FC00000; nv=1 only if either operand is sNaN; bypass=1.
  2. +inf and −inf → 0x7FC00000, nv=1, bypass=1.
  3. Any inf → that inf, bypass=1.
  4. Both zero → −0 if both negative, else +0; bypass=1.
  5. One zero → the other operand, post-flush; bypass=1.
  6. Equal magnitude, opposite sign → +0, bypass=1.
  7. add_overflow → {sign, 0xFF, 0} (inf), of=1.
  8. add_underflow → {sign, 0x00, 0} (zero), uf=1.
  9. Otherwise → add_result, flags 0.
- Ordering: strictly FIFO; no reordering or dropping.

## Timing
- Reset values: out_valid=0, out_result=0, out_tag=0, out_flags=0, count=0, rd_ptr=wr_ptr=0, in_ready=0 during reset and 1 in the cycle after release.
- Latency: a request accepted at edge N into an empty pipe issues in cycle N+1. out_valid is 1 after edge N+1, i.e. 2 cycles from in_valid to out_valid. A push and an issue never involve the same entry in one cycle.
- Throughput: 1 op/cycle with out_ready held high.
- Full: in_ready=0. Pop-and-push in the same cycle is not allowed while full; in_ready does not look ahead.
- Empty with push: count increments and no issue occurs that cycle.
- Stall: while out_valid && !out_ready, out_result, out_tag and out_flags hold stable. No issue occurs and the FIFO may still fill.
- Reset mid-operation: all buffered and registered requests are discarded and no output is produced.
- add_* inputs are sampled in the same cycle as the issue; the adder is purely combinational.

## Structure
- fpu_pkg holds:
  - typedef fp32_t packed struct {sign, exp[7:0], mant[22:0]}
  - typedef add_flags_t {nv, of, uf, bypass}
  - constants FP32_QNAN=32'h7FC00000, FP32_EXP_MAX=8'hFF
- Sub-module fp32_classify (combinational): input fp32_t; outputs the flushed value plus is_zero, is_inf, is_nan, is_snan. Two instances are used, one per operand.
- The adder is instanced in the parent, not inside this block.

## Test plan
- Reset: nRST=0 for 2 cycles with in_valid=1 → in_ready=0, out_valid=0, out_result=0. After release → in_ready=1 and nothing retired.
- 0x3F800000 + 0x40000000, adder model returns 0x40400000 → out_valid 2 cycles after accept, result 0x40400000, flags 0000.
- Special cases:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, nv=1, bypass=1.
  - 0x7F800001 + 0x3F800000 → 0x7FC00000, nv=1.
  - 0x80000000 + 0x80000000 → 0x80000000.
- 0x3F800000 + 0xBF800000 → 0x00000000, bypass=1. 0x00000001 + 0x3F800000 → 0x3F800000, bypass=1.
- 0x7F7FFFFF + 0x7F7FFFFF with add_overflow=1 → 0x7F800000, of=1.
- Backpressure, DEPTH=2, out_ready=0, push tags 0..3 → exactly 3 accepted, then in_ready=0. Raise out_ready → results retire for tags 0,1,2 back-to-back, then tag 3 is accepted and retires 2 cycles later.
